// File: rtl/rf_pkg.sv
// Shared types and sizes for the integer register file writeback path.
package rf_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  // Writeback source; also the encoding of the arbiter's last-grant state.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-input round-robin arbiter. Bit 0 is the ALU and bit 1 is the LSU.
// The last-grant state moves only when both inputs compete.
module wb_rr_arb
  import rf_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  wb_src_e last_q;

  // Grant selection: a lone requester always wins; on contention the other source wins.
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == WB_LSU) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Last-grant register; resets to LSU so the ALU wins the first contention.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q <= WB_LSU;
    end else if (valid_i == 2'b11) begin
      last_q <= grant_o[0] ? WB_ALU : WB_LSU;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler and scoreboard. Shares the single register file write port
// between the ALU and the LSU, and stalls issue on RAW/WAW hazards against
// destinations with an outstanding write.
module rf_wb_sched
  import rf_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  input  logic            i_issue_rd_en,
  input  reg_idx_t        i_issue_rd,
  input  reg_idx_t        i_issue_rs1,
  input  reg_idx_t        i_issue_rs2,
  output logic            o_issue_stall,
  input  logic            i_alu_valid,
  input  reg_idx_t        i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  output logic            o_alu_ready,
  input  logic            i_lsu_valid,
  input  reg_idx_t        i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  output logic            o_lsu_ready,
  output reg_idx_t        o_rd,
  output logic            o_rd_we,
  output logic [XLEN-1:0] o_rd_data,
  output logic [NREG-1:0] o_busy,
  output logic            o_wb_err
);

  logic [NREG-1:0] busy_q, busy_d;
  reg_idx_t        rd_q;
  logic            rd_we_q;
  logic [XLEN-1:0] rd_data_q;
  logic            err_q, err_d;

  logic [1:0]      grant;
  logic            gnt_any;
  reg_idx_t        gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            issue_fire;

  wb_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .valid_i ({i_lsu_valid, i_alu_valid}),
    .grant_o (grant)
  );

  // Handshake readiness and granted-request mux.
  always_comb begin
    o_alu_ready = grant[0];
    o_lsu_ready = grant[1];
    gnt_any     = |grant;
    gnt_rd      = grant[1] ? i_lsu_rd   : i_alu_rd;
    gnt_data    = grant[1] ? i_lsu_data : i_alu_data;
  end

  // Hazard stall; busy_q[0] is never set, so x0 never stalls.
  always_comb begin
    o_issue_stall = i_issue_valid &
                    (busy_q[i_issue_rs1] | busy_q[i_issue_rs2] |
                     (i_issue_rd_en & busy_q[i_issue_rd]));
    issue_fire    = i_issue_valid & ~o_issue_stall;
  end

  // Scoreboard and error next state; an issue set overrides a same-edge clear.
  always_comb begin
    busy_d = busy_q;
    if (rd_we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_fire && i_issue_rd_en && (i_issue_rd != '0)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    err_d = err_q | (gnt_any && (gnt_rd != '0) && !busy_q[gnt_rd]);
  end

  // Scoreboard, write-port output register and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy_q    <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      if (gnt_any) begin
        rd_q      <= gnt_rd;
        rd_data_q <= gnt_data;
        rd_we_q   <= (gnt_rd != '0);
      end else begin
        rd_we_q <= 1'b0;
      end
    end
  end

  assign o_rd      = rd_q;
  assign o_rd_we   = rd_we_q;
  assign o_rd_data = rd_data_q;
  assign o_busy    = busy_q;
  assign o_wb_err  = err_q;

endmodule
